// File: rtl/itype_decode_stage.sv
// I-type decode stage: decodes OP-IMM, LOAD and JALR into a single ID/EX register
// with valid/ready backpressure, flush, and a saturating illegal-instruction counter.
module itype_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_func3,
  output logic             out_srli_e,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rd,
  output logic             out_op_imm,
  output logic             out_load,
  output logic             out_jalr,
  output logic             out_reg_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  funct7;
  logic        dec_op_imm;
  logic        dec_load;
  logic        dec_jalr;
  logic        dec_legal;
  logic        dec_shift;
  logic [31:0] dec_imm;
  logic        dec_srli_e;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      imm_q, imm_d;
  logic [2:0]       func3_q, func3_d;
  logic             srli_e_q, srli_e_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rd_q, rd_d;
  logic             op_imm_q, op_imm_d;
  logic             load_q, load_d;
  logic             jalr_q, jalr_d;
  logic             reg_we_q, reg_we_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic xfer;
  logic capture;

  assign opcode = in_instr[6:0];
  assign func3  = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Legality and class: the opcode compare also covers the instr[1:0]==11 requirement.
  always_comb begin
    dec_op_imm = 1'b0;
    dec_load   = 1'b0;
    dec_jalr   = 1'b0;
    unique case (opcode)
      OPC_OP_IMM: begin
        if (func3 == 3'b001)      dec_op_imm = (funct7 == 7'b0000000);
        else if (func3 == 3'b101) dec_op_imm = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                      dec_op_imm = 1'b1;
      end
      OPC_LOAD: dec_load = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                           (func3 == 3'b100) || (func3 == 3'b101);
      OPC_JALR: dec_jalr = (func3 == 3'b000);
      default: ;
    endcase
    dec_legal  = dec_op_imm || dec_load || dec_jalr;
    dec_shift  = (opcode == OPC_OP_IMM) && ((func3 == 3'b001) || (func3 == 3'b101));
    dec_imm    = dec_shift ? {27'b0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
    dec_srli_e = ((opcode == OPC_OP_IMM) && (func3 == 3'b101)) ? ~in_instr[30] : 1'b1;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;
  assign capture  = xfer && !flush;

  // Flush wins over a same-cycle transfer and never touches data or the counter.
  always_comb begin
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    func3_d     = func3_q;
    srli_e_d    = srli_e_q;
    rs1_d       = rs1_q;
    rd_d        = rd_q;
    op_imm_d    = op_imm_q;
    load_d      = load_q;
    jalr_d      = jalr_q;
    reg_we_d    = reg_we_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    if (flush)          out_valid_d = 1'b0;
    else if (xfer)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    if (capture) begin
      pc_d      = in_pc;
      imm_d     = dec_imm;
      func3_d   = func3;
      srli_e_d  = dec_srli_e;
      rs1_d     = in_instr[19:15];
      rd_d      = in_instr[11:7];
      op_imm_d  = dec_op_imm;
      load_d    = dec_load;
      jalr_d    = dec_jalr;
      reg_we_d  = dec_legal && (in_instr[11:7] != 5'd0);
      illegal_d = !dec_legal;
      if (!dec_legal && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      func3_q     <= '0;
      srli_e_q    <= 1'b0;
      rs1_q       <= '0;
      rd_q        <= '0;
      op_imm_q    <= 1'b0;
      load_q      <= 1'b0;
      jalr_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      func3_q     <= func3_d;
      srli_e_q    <= srli_e_d;
      rs1_q       <= rs1_d;
      rd_q        <= rd_d;
      op_imm_q    <= op_imm_d;
      load_q      <= load_d;
      jalr_q      <= jalr_d;
      reg_we_q    <= reg_we_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = pc_q;
  assign out_imm     = imm_q;
  assign out_func3   = func3_q;
  assign out_srli_e  = srli_e_q;
  assign out_rs1     = rs1_q;
  assign out_rd      = rd_q;
  assign out_op_imm  = op_imm_q;
  assign out_load    = load_q;
  assign out_jalr    = jalr_q;
  assign out_reg_we  = reg_we_q;
  assign out_illegal = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_itype_decode_stage.sv
// Self-checking bench for itype_decode_stage: directed steps plus random traffic
// scored against a transaction-level queue model of the ID/EX register.
module tb_itype_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_func3;
  logic        out_srli_e;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rd;
  logic        out_op_imm;
  logic        out_load;
  logic        out_jalr;
  logic        out_reg_we;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  int checks = 0;
  int errors = 0;
  logic [82:0] sb[$];
  int unsigned m_cnt = 0;

  itype_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm), .out_func3(out_func3),
    .out_srli_e(out_srli_e), .out_rs1(out_rs1), .out_rd(out_rd),
    .out_op_imm(out_op_imm), .out_load(out_load), .out_jalr(out_jalr),
    .out_reg_we(out_reg_we), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode straight from the encoding rules; packed as
  // {pc, imm, func3, srli_e, rs1, rd, op_imm, load, jalr, reg_we, illegal}.
  function automatic logic [82:0] refDecode(input logic [31:0] i, input logic [31:0] pc);
    int opc = int'(i[6:0]);
    int f3  = int'(i[14:12]);
    int f7  = int'(i[31:25]);
    bit is_op, is_ld, is_jr, legal, srl;
    logic signed [11:0] simm;
    logic [31:0] imm;
    is_op = (opc == 'h13) && ((f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1);
    is_ld = (opc == 'h03) && (f3 inside {0, 1, 2, 4, 5});
    is_jr = (opc == 'h67) && (f3 == 0);
    legal = is_op || is_ld || is_jr;
    simm  = i[31:20];
    if (opc == 'h13 && (f3 == 1 || f3 == 5)) imm = 32'(int'(i[24:20]));
    else                                     imm = 32'(int'(simm));
    srl = (opc == 'h13 && f3 == 5) ? !i[30] : 1'b1;
    return {pc, imm, i[14:12], srl, i[19:15], i[11:7], is_op, is_ld, is_jr,
            legal && (i[11:7] != 5'd0), !legal};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] i;
    int sel;
    i   = $urandom;
    sel = $urandom_range(0, 5);
    case (sel)
      0, 3:    i[6:0] = 7'h13;
      1:       i[6:0] = 7'h03;
      2:       i[6:0] = 7'h67;
      default: ;
    endcase
    case ($urandom_range(0, 2))
      0: i[31:25] = 7'h00;
      1: i[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 2) == 0) i[14:12] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
    return i;
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares the DUT against the scoreboard before the coming clock edge.
  task automatic checkOutput(input string tag);
    logic [82:0] obs;
    obs = {out_pc, out_imm, out_func3, out_srli_e, out_rs1, out_rd,
           out_op_imm, out_load, out_jalr, out_reg_we, out_illegal};
    checkVal({tag, ".valid"}, out_valid, sb.size() != 0);
    checkVal({tag, ".in_ready"}, in_ready, (sb.size() == 0) || out_ready);
    checkVal({tag, ".cnt"}, illegal_cnt, m_cnt[15:0]);
    if (sb.size() != 0) checkVal({tag, ".fields"}, obs, sb[0]);
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic fl, input logic ordy);
    bit rdy;
    logic [82:0] d;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    flush     = fl;
    out_ready = ordy;
    #1;
    checkOutput(tag);
    rdy = (sb.size() == 0) || ordy;
    d   = refDecode(instr, pc);
    @(posedge clk);
    if (ordy && sb.size() != 0) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (v && rdy) begin
      sb.push_back(d);
      if (d[0] && m_cnt < 32'hFFFF) m_cnt++;
    end
    #1;
  endtask

  initial begin
    logic [31:0] ri;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    checkVal("rst.valid", out_valid, 1'b0);
    checkVal("rst.in_ready", in_ready, 1'b1);
    checkVal("rst.cnt", illegal_cnt, 16'h0);
    checkVal("rst.fields", {out_pc, out_imm, out_func3, out_srli_e, out_rs1, out_rd,
                            out_op_imm, out_load, out_jalr, out_reg_we, out_illegal}, 83'h0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("addi", 1'b1, 32'hFFF08293, 32'h100, 1'b0, 1'b1);
    checkVal("addi.imm", out_imm, 32'hFFFFFFFF);
    checkVal("addi.rd", out_rd, 5'd5);
    checkVal("addi.we", out_reg_we, 1'b1);
    applyStimulus("srai", 1'b1, 32'h4041D193, 32'h104, 1'b0, 1'b1);
    checkVal("srai.imm", out_imm, 32'h4);
    checkVal("srai.srli_e", out_srli_e, 1'b0);
    applyStimulus("srli", 1'b1, 32'h0041D193, 32'h108, 1'b0, 1'b1);
    checkVal("srli.srli_e", out_srli_e, 1'b1);
    applyStimulus("drain0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Four-instruction stream with a three-cycle stall after the second.
    applyStimulus("b2b.i1", 1'b1, 32'h00A00093, 32'h200, 1'b0, 1'b1);
    applyStimulus("b2b.i2", 1'b1, 32'h00402103, 32'h204, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus("b2b.stall", 1'b1, 32'h00008067, 32'h208, 1'b0, 1'b0);
    applyStimulus("b2b.i3", 1'b1, 32'h00008067, 32'h208, 1'b0, 1'b1);
    applyStimulus("b2b.i4", 1'b1, 32'h0030C213, 32'h20C, 1'b0, 1'b1);
    applyStimulus("b2b.drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    applyStimulus("ill", 1'b1, 32'h40109093, 32'h300, 1'b0, 1'b1);
    checkVal("ill.flag", out_illegal, 1'b1);
    checkVal("ill.cls", {out_op_imm, out_load, out_jalr, out_reg_we}, 4'b0);
    checkVal("ill.cnt", illegal_cnt, 16'd1);
    applyStimulus("ill.flush", 1'b1, 32'h40109093, 32'h304, 1'b1, 1'b1);
    checkVal("flush.valid", out_valid, 1'b0);
    checkVal("flush.cnt", illegal_cnt, 16'd1);

    for (int k = 0; k < 400; k++) begin
      ri = randInstr();
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0), ri, $urandom,
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));
    end

    // Fast-stream illegal encodings up to one below saturation.
    n = int'(32'hFFFE - m_cnt);
    in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    sb.delete();
    sb.push_back(refDecode(32'h0, 32'h0));
    m_cnt = 32'hFFFE;
    checkVal("sat.pre", illegal_cnt, 16'hFFFE);
    for (int k = 0; k < 3; k++) applyStimulus("sat", 1'b1, 32'h0, 32'h400 + 32'(k), 1'b0, 1'b1);
    applyStimulus("sat.idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkVal("sat.cnt", illegal_cnt, 16'hFFFF);

    // Asynchronous reset in the middle of a stall.
    applyStimulus("rst.load", 1'b1, 32'hFFF08293, 32'h500, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checkVal("stall.valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkVal("arst.valid", out_valid, 1'b0);
    checkVal("arst.cnt", illegal_cnt, 16'h0);
    checkVal("arst.in_ready", in_ready, 1'b1);
    sb.delete();
    m_cnt = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      ri = randInstr();
      applyStimulus("post", 1'b1, ri, $urandom, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/itype_decode_stage.md
# itype_decode_stage

Pipelined decode stage that produces the operand and control fields the I-type execute ALU consumes (sign-extended immediate, func3, shift-type select, rs1/rd, instruction class). It sits between the fetch buffer and the ID/EX boundary. It accepts one 32-bit instruction per valid/ready transfer, decodes OP-IMM, LOAD and JALR, flags every other encoding as illegal, and holds the result in a single ID/EX register. The register supports backpressure and flush, and the stage keeps a saturating illegal-instruction counter.

## Interface
- XLEN, 32 — data/PC width; only 32 supported
- CNT_W, 16 — width of illegal-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_instr/in_pc valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  PC of in_instr
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  ID/EX register holds a decoded instruction
- out_ready  in  1  execute consumes this cycle
- out_pc  out  XLEN  registered PC
- out_imm  out  32  decoded immediate
- out_func3  out  3  instr[14:12]
- out_srli_e  out  1  1 = logical right shift, 0 = arithmetic
- out_rs1, out_rd  out  5 each  register indices
- out_op_imm, out_load, out_jalr  out  1 each  one-hot class (all 0 if illegal)
- out_reg_we  out  1  legal and rd != 0
- out_illegal  out  1  decoded encoding illegal
- illegal_cnt  out  CNT_W  count of illegal instructions captured

## Operation
- Transfer: in_valid && in_ready. in_ready = !out_valid || out_ready (combinational; independent of flush).
- On transfer without flush, every out_* data field loads the decode of in_instr/in_pc and out_valid <= 1.
- Without a transfer, out_ready=1 clears out_valid; data fields hold their values.
- flush: out_valid <= 0 next edge, overriding any transfer in the same cycle. Data registers are not reloaded and illegal_cnt does not change.
- Legality:
  - instr[1:0] must be 11.
  - OP-IMM (0010011): all func3 legal, except func3=001, which needs instr[31:25]=0000000, and func3=101, which needs instr[31:25] ∈ {0000000, 0100000}.
  - LOAD (0000011): func3 ∈ {000,001,010,100,101}.
  - JALR (1100111): func3=000.
  - Any other opcode is illegal.
- Immediate:
  - Default: sign-extend instr[31:20].
  - OP-IMM func3 001/101: {27'b0, instr[24:20]} (zero-extended shamt; bit 30 never leaks into imm).
- out_srli_e = ~instr[30] for OP-IMM func3=101; otherwise 1.
- Illegal: out_illegal=1, class flags=0, out_reg_we=0. Other fields decode normally (don't-care to the consumer).
- illegal_cnt increments by 1 on each non-flushed transfer with an illegal decode. It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- Latency 1: a decode accepted at edge N is visible with out_valid=1 after edge N.
- Throughput 1/cycle while out_ready=1.
- While out_valid && !out_ready, all out_* fields are stable and in_ready=0.
- Reset (async, immediate on rst_n low; released synchronously on clk): all out_* data fields 0, out_valid 0, illegal_cnt 0. in_ready therefore reads 1 during reset.
- Reset asserted mid-stall: held instruction is lost and out_valid drops without waiting for a clock.
- Simultaneous out_ready and transfer: old entry retires, new entry loads on the same edge (no bubble).
- Simultaneous flush and out_ready: entry is discarded; the consumer must not treat it as executed.

## Test plan
- addi x5,x1,-1 (0xFFF08293), out_ready=1 → next cycle: out_valid=1, out_imm=0xFFFFFFFF, func3=000, rs1=1, rd=5, op_imm=1, reg_we=1, illegal=0.
- srai x3,x3,4 (0x4041D193) → out_imm=0x00000004, func3=101, srli_e=0. srli x3,x3,4 (0x0041D193) → srli_e=1, out_imm=0x00000004.
- Back-to-back stream of 4 instructions with out_ready low for 3 cycles after the 2nd → in_ready=0 and outputs frozen for exactly those 3 cycles. No instruction is lost or duplicated, and order is preserved.
- 0x40109093 (slli with funct7=0100000) → illegal=1, reg_we=0, class flags 0, illegal_cnt 0→1. The same encoding with flush high in the transfer cycle → out_valid=0, illegal_cnt unchanged.
- Force illegal_cnt to 0xFFFE by streaming illegal opcodes (e.g. 0x00000000), then send 3 more → count reads 0xFFFF and stays there.
- Drop rst_n low between edges while out_valid=1 and out_ready=0 → out_valid=0 and illegal_cnt=0 before the next clock edge. in_ready=1.
